// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared types and constants for the HWPE-Stream source
//
// Purpose: FSM state encoding and LFSR feedback polynomials used by the
// stream source and its LFSR sub-module, plus a 32-bit LFSR step helper.
// Ports: none (package).

package hwpe_stream_package;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Right-shifting Galois feedback masks.
  localparam logic [31:0] LFSR32_POLY = 32'h8020_0003;
  localparam logic [15:0] LFSR16_POLY = 16'hB400;

  // One step of the 32-bit payload LFSR; used to preload the next payload
  // word in the same cycle the LFSR register itself steps.
  function automatic logic [31:0] lfsr32_step(input logic [31:0] q);
    return (q >> 1) ^ (q[0] ? LFSR32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// rtl/hwpe_stream_intf_stream.sv - HWPE-Stream bundle (data, strb, valid, ready)
//
// Purpose: point-to-point stream carrying one DATA_WIDTH beat per handshake.
// Signals: valid, ready, data[DATA_WIDTH-1:0], strb[DATA_WIDTH/8-1:0].
// Modports: source drives valid/data/strb, sink drives ready.

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface

// File: rtl/tb_hwpe_stream_lfsr.sv
// rtl/tb_hwpe_stream_lfsr.sv - seeded right-shifting Galois LFSR
//
// Purpose: free-standing LFSR that steps once per cycle with en_i high.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset, reloads SEED
//   clear_i  in   synchronous soft clear, reloads SEED
//   en_i     in   step enable
//   q_o      out  current LFSR state [WIDTH-1:0]

module tb_hwpe_stream_lfsr
  import hwpe_stream_package::*;
#(
  parameter int unsigned        WIDTH = 32,
  parameter logic [WIDTH-1:0]   POLY  = LFSR32_POLY[WIDTH-1:0],
  parameter logic [WIDTH-1:0]   SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [WIDTH-1:0]   q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      q_q <= SEED;
    end else if (en_i) begin
      q_q <= (q_q >> 1) ^ (q_q[0] ? POLY : '0);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tb_hwpe_stream_source.sv
// rtl/tb_hwpe_stream_source.sv - programmable HWPE-Stream stimulus source
//
// Purpose: emits len_i beats on an HWPE-Stream with deterministic payload
// (beat index or 32-bit LFSR) and LFSR-driven valid gaps.
// Ports:
//   clk_i       in   clock
//   rst_ni      in   synchronous active-low reset
//   clear_i     in   synchronous soft clear (same effect as reset)
//   start_i     in   start a run (sampled in IDLE only)
//   len_i       in   beats per run, sampled with start_i
//   busy_o      out  high from the cycle after start through the final handshake
//   done_o      out  one-cycle pulse after the final handshake
//   beat_cnt_o  out  handshakes completed in the current or last run
//   data_o      src  HWPE-Stream source (valid/data/strb out, ready in)

module tb_hwpe_stream_source
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DATA_MODE    = 0,
  parameter int unsigned STALL_THRESH = 0,
  parameter logic [31:0] SEED         = 32'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [31:0]            len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            beat_cnt_o,
  hwpe_stream_intf_stream.source data_o
);

  localparam logic [15:0] STALL_SEED_X = SEED[15:0] ^ 16'hFFFF;
  // An all-zero seed would lock the stall LFSR at zero forever.
  localparam logic [15:0] STALL_SEED   = (STALL_SEED_X == 16'h0) ? 16'h0001 : STALL_SEED_X;
  // Nine bits so that 256 (never valid) is representable.
  localparam logic [8:0]  THRESH       = 9'(STALL_THRESH);
  localparam int unsigned REPS         = (DATA_WIDTH + 31) / 32;

  state_e                  state_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [31:0]             beat_cnt_q;
  logic [31:0]             len_q;

  logic [31:0]             pay_q;
  logic [15:0]             stall_q;
  logic                    stall_unused;

  logic                    hs;
  logic                    last_hs;
  logic                    run_draw;
  logic                    start_run;
  logic                    stall_gap;
  logic [DATA_WIDTH-1:0]   start_word;
  logic [DATA_WIDTH-1:0]   run_word;

  always_comb begin
    hs        = (state_q == ST_RUN) && valid_q && data_o.ready;
    last_hs   = hs && ((beat_cnt_q + 32'd1) == len_q);
    // A draw decides the next beat: whenever valid is low, or after a
    // non-final handshake. A held beat never draws, so it stays stable.
    run_draw  = (state_q == ST_RUN) && (!valid_q || (hs && !last_hs));
    start_run = (state_q == ST_IDLE) && start_i && (len_i != 32'd0);
    stall_gap = {1'b0, stall_q[7:0]} < THRESH;

    if (DATA_MODE == 1) begin
      start_word = DATA_WIDTH'({REPS{pay_q}});
      // After a handshake the payload LFSR steps at this same edge, so the
      // next beat must carry the stepped value.
      run_word   = DATA_WIDTH'({REPS{hs ? lfsr32_step(pay_q) : pay_q}});
    end else begin
      start_word = '0;
      run_word   = DATA_WIDTH'(hs ? (beat_cnt_q + 32'd1) : beat_cnt_q);
    end
  end

  tb_hwpe_stream_lfsr #(
    .WIDTH (32),
    .POLY  (LFSR32_POLY),
    .SEED  (SEED)
  ) i_pay_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (hs),
    .q_o     (pay_q)
  );

  tb_hwpe_stream_lfsr #(
    .WIDTH (16),
    .POLY  (LFSR16_POLY),
    .SEED  (STALL_SEED)
  ) i_stall_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (start_run || run_draw),
    .q_o     (stall_q)
  );

  // Upper stall bits only matter for the LFSR's own feedback.
  assign stall_unused = ^stall_q[15:8];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      beat_cnt_q <= 32'd0;
      len_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i != 32'd0) begin
              // Entering RUN doubles as the first draw so that valid can
              // rise the very next cycle.
              len_q      <= len_i;
              beat_cnt_q <= 32'd0;
              busy_q     <= 1'b1;
              state_q    <= ST_RUN;
              valid_q    <= !stall_gap;
              if (!stall_gap) begin
                data_q <= start_word;
              end
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
          end
          if (last_hs) begin
            state_q <= ST_DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (run_draw) begin
            valid_q <= !stall_gap;
            if (!stall_gap) begin
              data_q <= run_word;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_o.valid = valid_q;
  assign data_o.data  = data_q;
  assign data_o.strb  = '1;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign beat_cnt_o   = beat_cnt_q;

endmodule

// File: tb/tb_tb_hwpe_stream_source.sv
// tb/tb_tb_hwpe_stream_source.sv - self-checking bench for tb_hwpe_stream_source

module tb_tb_hwpe_stream_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] len;
  logic        ready;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s1 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s2 ();

  assign s0.ready = ready;
  assign s1.ready = ready;
  assign s2.ready = ready;

  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] cnt0, cnt1, cnt2;

  // dut0: counter payload, no gaps; dut1: counter payload, ~50% gaps;
  // dut2: LFSR payload, no gaps.
  tb_hwpe_stream_source #(.DATA_WIDTH(32), .DATA_MODE(0), .STALL_THRESH(0), .SEED(32'hACE1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .busy_o(busy0), .done_o(done0), .beat_cnt_o(cnt0), .data_o(s0));

  tb_hwpe_stream_source #(.DATA_WIDTH(32), .DATA_MODE(0), .STALL_THRESH(128), .SEED(32'hACE1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .busy_o(busy1), .done_o(done1), .beat_cnt_o(cnt1), .data_o(s1));

  tb_hwpe_stream_source #(.DATA_WIDTH(32), .DATA_MODE(1), .STALL_THRESH(0), .SEED(32'hACE1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .busy_o(busy2), .done_o(done2), .beat_cnt_o(cnt2), .data_o(s2));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  bit          mon0 = 0, mon1 = 0, mon2 = 0;
  int          hs1_cnt = 0;
  int          viol = 0;
  logic        p_valid = 0, p_hs = 0, p_rst = 0, p_clear = 0;
  logic [31:0] p_data = '0;

  // Scoreboard pops on every observed handshake; dut1 also gets a
  // hold-until-handshake check.
  always @(negedge clk) begin
    if (mon0 && s0.valid && s0.ready) begin
      if (q0.size() == 0) check_eq("dut0_extra_beat", 1, 0);
      else check_eq("dut0_beat", s0.data, q0.pop_front());
    end
    if (mon1 && s1.valid && s1.ready) begin
      hs1_cnt++;
      if (q1.size() == 0) check_eq("dut1_extra_beat", 1, 0);
      else check_eq("dut1_beat", s1.data, q1.pop_front());
    end
    if (mon2 && s2.valid && s2.ready) begin
      if (q2.size() == 0) check_eq("dut2_extra_beat", 1, 0);
      else check_eq("dut2_beat", s2.data, q2.pop_front());
    end
    if (mon1 && p_valid && !p_hs && p_rst && !p_clear && (!s1.valid || s1.data !== p_data))
      viol++;
    p_valid = s1.valid;
    p_hs    = s1.valid && s1.ready;
    p_data  = s1.data;
    p_rst   = rst_n;
    p_clear = clear;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    len   = 32'd0;
    ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  bit rdy[8000];
  bit tr[8000];

  initial begin
    int tr_mis;
    int ncyc;

    do_reset();
    @(negedge clk);
    check_eq("rst_valid", s0.valid, 0);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_done", done0, 0);
    check_eq("rst_cnt", cnt0, 0);

    // Basic run: len 4, ready high.
    mon0 = 1;
    for (int i = 0; i < 4; i++) q0.push_back(i);
    tick(); start = 1'b1; len = 32'd4;
    tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) check_eq("bas_valid_c1", s0.valid, 1);
      if (c == 4) begin
        check_eq("bas_busy_c4", busy0, 1);
        check_eq("bas_done_c4", done0, 0);
      end
      if (c == 5) begin
        check_eq("bas_done_c5", done0, 1);
        check_eq("bas_cnt_c5", cnt0, 4);
        check_eq("bas_busy_c5", busy0, 0);
        check_eq("bas_valid_c5", s0.valid, 0);
      end
      if (c == 6) check_eq("bas_done_c6", done0, 0);
      tick();
    end
    check_eq("bas_drain", q0.size(), 0);
    clear = 1'b1;
    tick(); clear = 1'b0;
    @(negedge clk);
    check_eq("clr_cnt", cnt0, 0);

    // Backpressure: ready low in cycles 2-3.
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(i);
    tick(); start = 1'b1; len = 32'd4;
    tick(); start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      ready = !(c == 2 || c == 3);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        check_eq("bp_valid_hold", s0.valid, 1);
        check_eq("bp_data_hold", s0.data, 1);
      end
      if (c == 6) check_eq("bp_done_c6", done0, 0);
      if (c == 7) check_eq("bp_done_c7", done0, 1);
      tick();
    end
    ready = 1'b1;
    check_eq("bp_drain", q0.size(), 0);

    // Zero length.
    do_reset();
    tick(); start = 1'b1; len = 32'd0;
    tick(); start = 1'b0;
    @(negedge clk);
    check_eq("zl_done_c1", done0, 1);
    check_eq("zl_valid_c1", s0.valid, 0);
    check_eq("zl_cnt_c1", cnt0, 0);
    tick();
    @(negedge clk);
    check_eq("zl_done_c2", done0, 0);
    check_eq("zl_valid_c2", s0.valid, 0);

    // Random gaps and random ready, run twice with the same ready pattern.
    for (int c = 0; c < 8000; c++) rdy[c] = ($urandom_range(0, 3) != 0);
    tr_mis = 0;
    ncyc   = 0;
    for (int r = 0; r < 2; r++) begin
      bit fin0, fin1;
      int c, c1;
      do_reset();
      for (int i = 0; i < 1000; i++) begin
        q0.push_back(i);
        q1.push_back(i);
      end
      hs1_cnt = 0;
      mon1    = 1;
      fin0    = 0;
      fin1    = 0;
      c1      = 0;
      tick(); start = 1'b1; len = 32'd1000; ready = rdy[0];
      tick(); start = 1'b0;
      c = 1;
      while (!(fin0 && fin1) && c < 8000) begin
        ready = rdy[c];
        @(negedge clk);
        if (!fin1) begin
          if (r == 0) tr[c] = s1.valid;
          else if (tr[c] !== s1.valid) tr_mis++;
        end
        if (done0) fin0 = 1;
        if (done1 && !fin1) begin
          fin1 = 1;
          c1   = c;
        end
        tick();
        c++;
      end
      check_eq("rnd_done0_seen", fin0, 1);
      check_eq("rnd_done1_seen", fin1, 1);
      check_eq("rnd_hs_count", hs1_cnt, 1000);
      check_eq("rnd_cnt1", cnt1, 1000);
      check_eq("rnd_q0_drain", q0.size(), 0);
      check_eq("rnd_q1_drain", q1.size(), 0);
      if (r == 0) ncyc = c1;
      else check_eq("rnd_run_length", c1, ncyc);
      mon1 = 0;
    end
    check_eq("rnd_trace", tr_mis, 0);
    check_eq("rnd_stable", viol, 0);
    q0.delete();
    q1.delete();

    // LFSR payload.
    do_reset();
    mon0 = 0;
    mon2 = 1;
    q2.push_back(32'h0000_ACE1);
    q2.push_back(32'h8020_5673);
    tick(); start = 1'b1; len = 32'd2;
    tick(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) check_eq("lf_done_c3", done2, 1);
      tick();
    end
    check_eq("lf_drain", q2.size(), 0);
    mon2 = 0;

    // Abort via reset at beat 3, then restart with an ignored mid-run start.
    do_reset();
    mon0 = 1;
    for (int i = 0; i < 4; i++) q0.push_back(i);
    tick(); start = 1'b1; len = 32'd8;
    tick(); start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("ab_data_c4", s0.data, 3);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check_eq("ab_valid_after", s0.valid, 0);
    check_eq("ab_done_after", done0, 0);
    check_eq("ab_busy_after", busy0, 0);
    tick();
    @(negedge clk);
    check_eq("ab_done_after2", done0, 0);
    check_eq("ab_drain", q0.size(), 0);
    for (int i = 0; i < 8; i++) q0.push_back(i);
    tick(); start = 1'b1; len = 32'd8;
    tick(); start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        start = 1'b1;
        len   = 32'd3;
      end
      if (c == 4) start = 1'b0;
      @(negedge clk);
      if (c == 8) begin
        check_eq("rs_busy_c8", busy0, 1);
        check_eq("rs_done_c8", done0, 0);
      end
      if (c == 9) begin
        check_eq("rs_done_c9", done0, 1);
        check_eq("rs_cnt_c9", cnt0, 8);
      end
      tick();
    end
    check_eq("rs_drain", q0.size(), 0);
    mon0 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
